// File: rtl/cpu_pkg.sv
// Shared types, widths and the 2-bit saturating counter update used by the branch resolver.
package cpu_pkg;

  localparam int unsigned PC_W     = 32;
  localparam logic [1:0]  BHT_INIT = 2'b01;

  typedef enum logic {
    RSV_IDLE,
    RSV_REDIRECT
  } rsv_state_e;

  // Saturating 2-bit counter step: +1 on taken, -1 on not taken, clamped to 00..11.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && (ctr != 2'b11)) begin
      res = ctr + 2'd1;
    end else if (!taken && (ctr != 2'b00)) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/FA_32bit.sv
// 32-bit adder shared with fetch for sequential next-PC computation.
module FA_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum
);

  // Plain ripple/synthesised add; carry-out is not needed by any consumer.
  assign o_sum = i_a + i_b + 32'(i_cin);

endmodule

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with one read and one update port.
module bht_2bit
  import cpu_pkg::*;
#(
  parameter  int unsigned BHT_ENTRIES = 64,
  localparam int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_taken,
  output logic [1:0]       o_rd_ctr_c,
  output logic [1:0]       o_upd_ctr_c
);

  logic [1:0] ctr_q [BHT_ENTRIES];
  logic [1:0] ctr_d [BHT_ENTRIES];

  // Read port plus the value that entry would take after this outcome.
  assign o_rd_ctr_c  = ctr_q[i_rd_idx];
  assign o_upd_ctr_c = ctr_update(o_rd_ctr_c, i_taken);

  // Update the addressed counter on a write strobe.
  always_comb begin
    ctr_d = ctr_q;
    if (i_wr_en) begin
      ctr_d[i_wr_idx] = ctr_update(ctr_q[i_wr_idx], i_taken);
    end
  end

  // Counter storage; every entry starts weakly not-taken.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves control flow in ID against the fetch prediction; drives redirect/flush/kill,
// BTB write-back, BHT training and saturating perf counters.
module branch_resolver
  import cpu_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter bit          INSERT_JALR = 1'b0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_valid,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic             i_taken,
  input  logic [PC_W-1:0]  i_target,
  input  logic             i_pred_taken,
  input  logic [PC_W-1:0]  i_pred_target,
  output logic             o_redirect_valid,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_kill_id,
  output logic             o_btb_update,
  output logic [PC_W-1:0]  o_btb_update_pc,
  output logic [PC_W-1:0]  o_btb_update_target,
  output logic [CNT_W-1:0] o_ctrl_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  rsv_state_e       state_q, state_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic             kill_id_q, kill_id_d;
  logic             btb_update_q, btb_update_d;
  logic [PC_W-1:0]  btb_pc_q, btb_pc_d;
  logic [PC_W-1:0]  btb_target_q, btb_target_d;
  logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [PC_W-1:0]  pc_plus4_c;
  logic [IDX_W-1:0] bht_idx_c;
  logic [1:0]       bht_rd_ctr_unused;
  logic [1:0]       bht_upd_ctr_c;
  logic             accept_c;
  logic             is_ctrl_c;
  logic             taken_act_c;
  logic [PC_W-1:0]  next_act_c;
  logic             mispred_c;
  logic             btb_ins_c;

  // Sequential next PC, computed the same way fetch does.
  FA_32bit u_pc_add (
    .i_a   (i_pc),
    .i_b   (32'd4),
    .i_cin (1'b0),
    .o_sum (pc_plus4_c)
  );

  assign bht_idx_c = i_pc[IDX_W+1:2];

  // Direction history; trained only by accepted conditional branches.
  bht_2bit #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rd_idx    (bht_idx_c),
    .i_wr_en     (accept_c & i_is_branch),
    .i_wr_idx    (bht_idx_c),
    .i_taken     (i_taken),
    .o_rd_ctr_c  (bht_rd_ctr_unused),
    .o_upd_ctr_c (bht_upd_ctr_c)
  );

  // Actual outcome versus prediction for the instruction currently in ID.
  always_comb begin
    accept_c    = i_valid & ~i_stall & (state_q == RSV_IDLE);
    is_ctrl_c   = i_is_branch | i_is_jal | i_is_jalr;
    taken_act_c = i_is_jal | i_is_jalr | (i_is_branch & i_taken);
    next_act_c  = taken_act_c ? i_target : pc_plus4_c;
    mispred_c   = (i_pred_taken != taken_act_c) |
                  (i_pred_taken & taken_act_c & (i_pred_target != i_target));
    btb_ins_c   = accept_c & taken_act_c &
                  (i_is_jal | (i_is_jalr & INSERT_JALR) |
                   (i_is_branch & (bht_upd_ctr_c >= 2'b10)));
  end

  // Redirect FSM: raise on an accepted mispredict, hold until fetch is unstalled.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    kill_id_d        = kill_id_q;
    unique case (state_q)
      RSV_IDLE: begin
        if (accept_c && mispred_c) begin
          state_d          = RSV_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = next_act_c;
          flush_d          = 1'b1;
          kill_id_d        = 1'b1;
        end
      end
      RSV_REDIRECT: begin
        if (!i_stall) begin
          state_d          = RSV_IDLE;
          redirect_valid_d = 1'b0;
          redirect_pc_d    = '0;
          flush_d          = 1'b0;
          kill_id_d        = 1'b0;
        end
      end
      default: begin
        state_d = RSV_IDLE;
      end
    endcase
  end

  // One-cycle BTB write strobe and saturating perf counters.
  always_comb begin
    btb_update_d  = btb_ins_c;
    btb_pc_d      = btb_ins_c ? i_pc : '0;
    btb_target_d  = btb_ins_c ? i_target : '0;
    ctrl_cnt_d    = ctrl_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept_c && is_ctrl_c && (ctrl_cnt_q != {CNT_W{1'b1}})) begin
      ctrl_cnt_d = ctrl_cnt_q + CNT_W'(1);
    end
    if (accept_c && mispred_c && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Output and state registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q          <= RSV_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      kill_id_q        <= 1'b0;
      btb_update_q     <= 1'b0;
      btb_pc_q         <= '0;
      btb_target_q     <= '0;
      ctrl_cnt_q       <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      kill_id_q        <= kill_id_d;
      btb_update_q     <= btb_update_d;
      btb_pc_q         <= btb_pc_d;
      btb_target_q     <= btb_target_d;
      ctrl_cnt_q       <= ctrl_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign o_redirect_valid    = redirect_valid_q;
  assign o_redirect_pc       = redirect_pc_q;
  assign o_flush             = flush_q;
  assign o_kill_id           = kill_id_q;
  assign o_btb_update        = btb_update_q;
  assign o_btb_update_pc     = btb_pc_q;
  assign o_btb_update_target = btb_target_q;
  assign o_ctrl_cnt          = ctrl_cnt_q;
  assign o_mispred_cnt       = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed plus randomized checking of branch_resolver against a behavioural model.
module tb_branch_resolver;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned BHT_N   = 64;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_stall, i_valid, i_is_branch, i_is_jal, i_is_jalr, i_taken, i_pred_taken;
  logic [31:0]      i_pc, i_target, i_pred_target;
  logic             o_redirect_valid, o_flush, o_kill_id, o_btb_update;
  logic [31:0]      o_redirect_pc, o_btb_update_pc, o_btb_update_target;
  logic [CNT_W-1:0] o_ctrl_cnt, o_mispred_cnt;

  branch_resolver #(
    .BHT_ENTRIES (BHT_N),
    .INSERT_JALR (1'b0),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_stall             (i_stall),
    .i_valid             (i_valid),
    .i_pc                (i_pc),
    .i_is_branch         (i_is_branch),
    .i_is_jal            (i_is_jal),
    .i_is_jalr           (i_is_jalr),
    .i_taken             (i_taken),
    .i_target            (i_target),
    .i_pred_taken        (i_pred_taken),
    .i_pred_target       (i_pred_target),
    .o_redirect_valid    (o_redirect_valid),
    .o_redirect_pc       (o_redirect_pc),
    .o_flush             (o_flush),
    .o_kill_id           (o_kill_id),
    .o_btb_update        (o_btb_update),
    .o_btb_update_pc     (o_btb_update_pc),
    .o_btb_update_target (o_btb_update_target),
    .o_ctrl_cnt          (o_ctrl_cnt),
    .o_mispred_cnt       (o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_bht [BHT_N];
  bit          m_redir;
  logic [31:0] m_rpc;
  bit          m_btb;
  logic [31:0] m_btb_pc, m_btb_tgt;
  int          m_ctrl, m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(BHT_N); i++) m_bht[i] = 1;
    m_redir = 0; m_rpc = '0; m_btb = 0; m_btb_pc = '0; m_btb_tgt = '0;
    m_ctrl = 0; m_mis = 0;
  endtask

  // Apply one clock of the rules to the inputs currently on the pins.
  task automatic model_step();
    bit accept, taken_act, mis, ctrl;
    logic [31:0] nxt;
    int idx;
    accept    = i_valid && !i_stall && !m_redir;
    ctrl      = i_is_branch || i_is_jal || i_is_jalr;
    taken_act = i_is_jal || i_is_jalr || (i_is_branch && i_taken);
    nxt       = taken_act ? i_target : i_pc + 32'd4;
    mis       = (i_pred_taken != taken_act) ||
                (i_pred_taken && taken_act && (i_pred_target != i_target));
    idx       = int'(i_pc[7:2]);
    if (accept && i_is_branch) begin
      if (i_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else         m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    m_btb = accept && taken_act && (i_is_jal || (i_is_branch && m_bht[idx] >= 2));
    m_btb_pc  = i_pc;
    m_btb_tgt = i_target;
    if (accept && ctrl && m_ctrl < CNT_MAX) m_ctrl++;
    if (accept && mis && m_mis < CNT_MAX) m_mis++;
    if (m_redir) begin
      if (!i_stall) m_redir = 0;
    end else if (accept && mis) begin
      m_redir = 1;
      m_rpc   = nxt;
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".redirect_valid"}, 32'(o_redirect_valid), 32'(m_redir));
    check({pfx, ".flush"}, 32'(o_flush), 32'(m_redir));
    check({pfx, ".kill_id"}, 32'(o_kill_id), 32'(m_redir));
    if (m_redir) check({pfx, ".redirect_pc"}, o_redirect_pc, m_rpc);
    check({pfx, ".btb_update"}, 32'(o_btb_update), 32'(m_btb));
    if (m_btb) begin
      check({pfx, ".btb_pc"}, o_btb_update_pc, m_btb_pc);
      check({pfx, ".btb_target"}, o_btb_update_target, m_btb_tgt);
    end
    check({pfx, ".ctrl_cnt"}, 32'(o_ctrl_cnt), 32'(m_ctrl));
    check({pfx, ".mispred_cnt"}, 32'(o_mispred_cnt), 32'(m_mis));
  endtask

  // kind: 0 = non-control, 1 = branch, 2 = jal, 3 = jalr
  task automatic drive(input bit v, input bit st, input int kind, input logic [31:0] pc,
                       input bit tk, input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
    i_valid = v; i_stall = st;
    i_is_branch = (kind == 1); i_is_jal = (kind == 2); i_is_jalr = (kind == 3);
    i_pc = pc; i_taken = tk; i_target = tgt; i_pred_taken = pt; i_pred_target = ptg;
  endtask

  task automatic step(input string pfx);
    @(posedge i_clk);
    model_step();
    #1;
    check_all(pfx);
  endtask

  task automatic idle_step(input string pfx);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(pfx);
  endtask

  initial begin
    logic [31:0] rpc, rtgt, rptg;
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    model_reset();

    // 1: reset state
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    for (int i = 0; i < int'(BHT_N); i++)
      check($sformatf("reset.bht[%0d]", i), 32'(dut.u_bht.ctr_q[i]), 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;

    // 2: taken BEQ predicted not-taken
    drive(1, 0, 1, 32'h40, 1, 32'h80, 0, 32'h0);
    step("t2");
    check("t2.redirect_pc_abs", o_redirect_pc, 32'h80);
    check("t2.bht16", 32'(dut.u_bht.ctr_q[16]), 32'd2);
    check("t2.btb_target_abs", o_btb_update_target, 32'h80);
    idle_step("t2.drain");

    // 3: same branch predicted taken, actually not taken
    drive(1, 0, 1, 32'h40, 0, 32'h80, 1, 32'h80);
    step("t3");
    check("t3.redirect_pc_abs", o_redirect_pc, 32'h44);
    check("t3.bht16", 32'(dut.u_bht.ctr_q[16]), 32'd1);
    check("t3.no_btb", 32'(o_btb_update), 32'd0);
    idle_step("t3.drain");

    // PC wrap on the sequential path
    drive(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10);
    step("wrap");
    check("wrap.redirect_pc_abs", o_redirect_pc, 32'h0);
    idle_step("wrap.drain");

    // Non-control instruction predicted taken
    drive(1, 0, 0, 32'h60, 0, 32'h0, 1, 32'h90);
    step("nonctrl");
    check("nonctrl.redirect_pc_abs", o_redirect_pc, 32'h64);
    idle_step("nonctrl.drain");

    // 4: mispredict, then stall three cycles with valid ignored
    drive(1, 0, 1, 32'h80, 1, 32'h100, 0, 32'h0);
    step("t4");
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 32'h44, 1, 32'h300, 0, 32'h0);
      step($sformatf("t4.hold%0d", k));
      check($sformatf("t4.hold%0d_abs", k), 32'(o_redirect_valid), 32'd1);
    end
    drive(1, 0, 1, 32'h44, 1, 32'h300, 0, 32'h0);
    step("t4.release");
    check("t4.released_abs", 32'(o_redirect_valid), 32'd0);
    check("t4.ctrl_cnt_abs", 32'(o_ctrl_cnt), 32'd4);
    idle_step("t4.drain");

    // 5: correctly predicted JAL, then JALR without BTB insertion
    drive(1, 0, 2, 32'h100, 0, 32'h200, 1, 32'h200);
    step("t5.jal");
    check("t5.jal_btb_pc_abs", o_btb_update_pc, 32'h100);
    check("t5.jal_no_redirect", 32'(o_redirect_valid), 32'd0);
    drive(1, 0, 3, 32'h104, 0, 32'h400, 1, 32'h400);
    step("t5.jalr");
    check("t5.jalr_no_btb", 32'(o_btb_update), 32'd0);

    // 6: drive mispredict counter to saturation and beyond
    for (int k = 0; k < CNT_MAX + 2; k++) begin
      drive(1, 0, 0, 32'h200 + 32'(k * 4), 0, 32'h0, 1, 32'h500);
      step($sformatf("t6.mis%0d", k));
      if (k < CNT_MAX + 1) idle_step($sformatf("t6.drain%0d", k));
    end
    check("t6.sat_abs", 32'(o_mispred_cnt), 32'(CNT_MAX));

    // Asynchronous reset while redirecting
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    check("t6.rst_redirect", 32'(o_redirect_valid), 32'd0);
    check("t6.rst_mispred", 32'(o_mispred_cnt), 32'd0);
    check_all("t6.rst");
    @(negedge i_clk);
    i_reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 23)) << 2;
      rtgt = 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 2))
        0:       rptg = rtgt;
        1:       rptg = rpc + 32'd4;
        default: rptg = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
            rpc, 1'($urandom_range(0, 1)), rtgt, 1'($urandom_range(0, 1)), rptg);
      step($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
